// File: rtl/mult.sv
// rtl/mult.sv - Multicycle radix-2 Booth signed multiplier producing a 2*WIDTH-bit HI/LO product
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   a            multiplicand (two's complement), sampled on the start edge
//   b            multiplier (two's complement), sampled on the start edge
//   multControl  start request; high at a rising edge starts (or restarts) an operation
//   multStop     one-cycle done pulse; hi/lo are valid from this cycle onwards
//   hi           upper WIDTH bits of the product
//   lo           lower WIDTH bits of the product

module mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             multControl,
    output logic             multStop,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH:0]   r_m, w_m_nxt;
    logic [WIDTH:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic             r_q1, w_q1_nxt;
    logic [5:0]       r_count, w_count_nxt;
    logic [WIDTH-1:0] r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_lo, w_lo_nxt;
    logic             r_stop, w_stop_nxt;

    // One Booth step: add/subtract the multiplicand according to the
    // {Q[0], Q_1} pair, then arithmetic shift right of {A, Q, Q_1}.
    // The extra accumulator bit keeps the most-negative squared case exact.
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_a_shift;
    logic [WIDTH-1:0] w_q_shift;

    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
        w_a_shift = {w_sum[WIDTH], w_sum[WIDTH:1]};
        w_q_shift = {w_sum[0], r_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_stop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_m     <= w_m_nxt;
            r_a     <= w_a_nxt;
            r_q     <= w_q_nxt;
            r_q1    <= w_q1_nxt;
            r_count <= w_count_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_stop  <= w_stop_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_a_nxt     = r_a;
        w_q_nxt     = r_q;
        w_q1_nxt    = r_q1;
        w_count_nxt = r_count;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_stop_nxt  = 1'b0;

        // A start request wins over everything, including the final step,
        // so a restart on the completing edge suppresses that done pulse.
        if (multControl) begin
            w_m_nxt     = {a[WIDTH-1], a};
            w_a_nxt     = '0;
            w_q_nxt     = b;
            w_q1_nxt    = 1'b0;
            w_count_nxt = '0;
            w_hi_nxt    = '0;
            w_lo_nxt    = '0;
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    w_a_nxt     = w_a_shift;
                    w_q_nxt     = w_q_shift;
                    w_q1_nxt    = r_q[0];
                    w_count_nxt = r_count + 6'd1;
                    if (r_count == LAST_STEP) begin
                        w_hi_nxt    = w_a_shift[WIDTH-1:0];
                        w_lo_nxt    = w_q_shift;
                        w_stop_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign multStop = r_stop;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mult.sv
// tb/tb_mult.sv - Self-checking testbench for mult
module tb_mult;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        multControl = 1'b0;
    logic        multStop;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    mult #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .multControl(multControl),
        .multStop   (multStop),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_prod(input logic [31:0] x, input logic [31:0] y);
        longint px, py;
        px = longint'($signed(x));
        py = longint'($signed(y));
        return 64'(px * py);
    endfunction

    // Drive a one-cycle start pulse; returns at the negedge after the start edge.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a = x;
        b = y;
        multControl = 1'b1;
        @(negedge clk);
        multControl = 1'b0;
    endtask

    // Count negedges until multStop is seen; -1 if the bound expires.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (multStop === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1 reset = 1'b0;
        #1;
        checks++;
        if (multStop !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: stop=%b hi=%h lo=%h required 0/0/0", multStop, hi, lo);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (multStop !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL reset_idle: stop=%b hi=%h lo=%h required 0/0/0", multStop, hi, lo);
        end
    endtask

    task automatic test_directed;
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [31:0] eh [6];
        logic [31:0] el [6];
        int lat;
        va = '{32'h3, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h0};
        vb = '{32'h5, 32'h5, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h12345678};
        eh = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'h40000000, 32'h3FFFFFFF, 32'h0};
        el = '{32'hF, 32'hFFFFFFF1, 32'h1, 32'h0, 32'h1, 32'h0};
        for (int k = 0; k < 6; k++) begin
            start_op(va[k], vb[k]);
            checks++;
            if (hi !== 32'h0 || lo !== 32'h0 || multStop !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_cleared: stop=%b hi=%h lo=%h required 0/0/0", k, multStop, hi, lo);
            end
            wait_done(lat);
            checks++;
            if (lat !== 32) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d required 32", k, lat);
            end
            checks++;
            if (hi !== eh[k] || lo !== el[k]) begin
                failures++;
                $display("FAIL dir%0d_product: got %h_%h required %h_%h", k, hi, lo, eh[k], el[k]);
            end
            @(negedge clk);
            checks++;
            if (multStop !== 1'b0 || hi !== eh[k] || lo !== el[k]) begin
                failures++;
                $display("FAIL dir%0d_after: stop=%b hi=%h lo=%h required 0/%h/%h", k, multStop, hi, lo, eh[k], el[k]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] x, y;
        logic [63:0] p;
        int lat;
        for (int k = 0; k < 10; k++) begin
            x = $urandom;
            y = $urandom;
            if (k == 0) y = 32'h1;
            if (k == 1) x = 32'h80000000;
            p = model_prod(x, y);
            start_op(x, y);
            // operands changing after the start edge must be ignored
            a = $urandom;
            b = $urandom;
            wait_done(lat);
            checks++;
            if (lat !== 32 || hi !== p[63:32] || lo !== p[31:0]) begin
                failures++;
                $display("FAIL rand%0d: a=%h b=%h lat=%0d got %h_%h required lat=32 %h_%h", k, x, y, lat, hi, lo, p[63:32], p[31:0]);
            end
        end
    endtask

    task automatic test_restart;
        int lat;
        start_op(32'd7, 32'd9);
        repeat (9) @(negedge clk);
        start_op(32'd2, 32'hFFFFFFFE);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || multStop !== 1'b0) begin
            failures++;
            $display("FAIL restart_cleared: stop=%b hi=%h lo=%h required 0/0/0", multStop, hi, lo);
        end
        wait_done(lat);
        checks++;
        if (lat !== 32) begin
            failures++;
            $display("FAIL restart_latency: got %0d required 32", lat);
        end
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFC) begin
            failures++;
            $display("FAIL restart_product: got %h_%h required ffffffff_fffffffc", hi, lo);
        end
    endtask

    task automatic test_restart_last_edge;
        logic [31:0] x, y;
        logic [63:0] p;
        int lat;
        int seen;
        seen = 0;
        start_op(32'd11, 32'd13);
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (multStop === 1'b1) seen++;
        end
        x = $urandom;
        y = $urandom;
        p = model_prod(x, y);
        a = x;
        b = y;
        multControl = 1'b1;
        @(negedge clk);
        multControl = 1'b0;
        if (multStop === 1'b1) seen++;
        checks++;
        if (seen !== 0 || hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL restart_e32: pulses=%0d hi=%h lo=%h required 0/0/0", seen, hi, lo);
        end
        wait_done(lat);
        checks++;
        if (lat !== 32 || hi !== p[63:32] || lo !== p[31:0]) begin
            failures++;
            $display("FAIL restart_e32_product: lat=%0d got %h_%h required lat=32 %h_%h", lat, hi, lo, p[63:32], p[31:0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] x, y;
        logic [63:0] p;
        int lat;
        start_op(32'd100, 32'hFFFFFF00);
        wait_done(lat);
        x = $urandom;
        y = $urandom;
        p = model_prod(x, y);
        // start accepted while in DONE
        a = x;
        b = y;
        multControl = 1'b1;
        @(negedge clk);
        multControl = 1'b0;
        checks++;
        if (multStop !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL b2b_cleared: stop=%b hi=%h lo=%h required 0/0/0", multStop, hi, lo);
        end
        wait_done(lat);
        checks++;
        if (lat !== 32 || hi !== p[63:32] || lo !== p[31:0]) begin
            failures++;
            $display("FAIL b2b_product: lat=%0d got %h_%h required lat=32 %h_%h", lat, hi, lo, p[63:32], p[31:0]);
        end
    endtask

    task automatic test_reset_midop;
        int seen;
        int lat;
        seen = 0;
        start_op(32'd6, 32'd7);
        repeat (15) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (multStop !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL midop_reset: stop=%b hi=%h lo=%h required 0/0/0", multStop, hi, lo);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (multStop === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midop_no_stop: pulses=%0d required 0", seen);
        end
        start_op(32'd6, 32'd7);
        wait_done(lat);
        checks++;
        if (lat !== 32 || hi !== 32'h0 || lo !== 32'h2A) begin
            failures++;
            $display("FAIL midop_rerun: lat=%0d got %h_%h required lat=32 00000000_0000002a", lat, hi, lo);
        end
    endtask

    task automatic test_hold;
        logic [31:0] x, y;
        logic [63:0] p;
        int lat;
        int bad;
        bad = 0;
        x = $urandom;
        y = $urandom;
        p = model_prod(x, y);
        start_op(x, y);
        wait_done(lat);
        for (int i = 0; i < 50; i++) begin
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            if (multStop !== 1'b0 || hi !== p[63:32] || lo !== p[31:0]) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL hold: %0d bad cycles, last hi=%h lo=%h stop=%b required 0 bad, %h_%h", bad, hi, lo, multStop, p[63:32], p[31:0]);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_restart;
        test_restart_last_edge;
        test_back_to_back;
        test_reset_midop;
        test_hold;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
